// File: rtl/spi_slave_port.sv
// SPI mode-0 slave with 16-bit words, MCLK-domain oversampling of SCLK/CSS/MOSI,
// single-entry TX holding register and single-entry RX output register.
`timescale 1ns/1ps
module spi_slave_port #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        MCLK,
  input  logic        RESET_N,
  input  logic        SCLK,
  input  logic        CSS,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [15:0] TX_DATA,
  input  logic        TX_LOAD,
  output logic        TX_FULL,
  output logic [15:0] RX_DATA,
  output logic        RX_VALID,
  input  logic        RX_ACK,
  output logic        RX_OVERRUN,
  output logic        FRAME_ERR,
  output logic        BUSY
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sclk_sync, css_sync, mosi_sync;
  logic [SYNC_STAGES:0]   settle_pipe;
  logic                   sclk_d, css_d, css_armed;
  logic                   sclk_s, css_s, mosi_s;
  logic                   sclk_rise, sclk_fall, css_fall, css_rise;
  logic                   enter, rise_evt, fall_evt, ferr_evt, load_evt;
  logic [15:0]            tx_hold, tx_sh, rx_sh, load_word;
  logic [3:0]             bit_cnt;
  logic                   reload_pend, done_q;

  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sclk_sync   <= '0;
      css_sync    <= '1;
      mosi_sync   <= '0;
      sclk_d      <= 1'b0;
      css_d       <= 1'b1;
      settle_pipe <= '0;
      css_armed   <= 1'b0;
    end else begin
      sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      css_sync    <= {css_sync[SYNC_STAGES-2:0],  CSS};
      mosi_sync   <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sclk_d      <= sclk_s;
      css_d       <= css_s;
      settle_pipe <= {settle_pipe[SYNC_STAGES-1:0], 1'b1};
      // A CSS held low through reset release must go high before a frame may start.
      css_armed   <= css_armed | (settle_pipe[SYNC_STAGES] & css_s);
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign css_s     = css_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign css_fall  = css_armed & css_d & ~css_s;
  assign css_rise  = css_s & ~css_d;

  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (css_fall) state_nxt = ACTIVE;
      ACTIVE:  if (css_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    BUSY     = (state == ACTIVE);
    MISO     = BUSY & tx_sh[15];
    enter    = (state == IDLE) & css_fall;
    rise_evt = BUSY & ~css_rise & sclk_rise;
    fall_evt = BUSY & ~css_rise & sclk_fall;
    ferr_evt = BUSY & css_rise & (bit_cnt != 4'd0);
    load_evt = enter | (fall_evt & reload_pend);
  end

  // A strobe landing on a load event bypasses the holding register.
  assign load_word = TX_LOAD ? TX_DATA : (TX_FULL ? tx_hold : 16'h0000);

  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tx_hold     <= '0;
      TX_FULL     <= 1'b0;
      tx_sh       <= '0;
      rx_sh       <= '0;
      bit_cnt     <= '0;
      reload_pend <= 1'b0;
      done_q      <= 1'b0;
      RX_DATA     <= '0;
      RX_VALID    <= 1'b0;
      RX_OVERRUN  <= 1'b0;
      FRAME_ERR   <= 1'b0;
    end else begin
      if (TX_LOAD) tx_hold <= TX_DATA;
      if (load_evt)     TX_FULL <= 1'b0;
      else if (TX_LOAD) TX_FULL <= 1'b1;

      if (load_evt)      tx_sh <= load_word;
      else if (fall_evt) tx_sh <= {tx_sh[14:0], 1'b0};

      if (enter)         bit_cnt <= '0;
      else if (rise_evt) bit_cnt <= bit_cnt + 4'd1;

      if (enter)                              reload_pend <= 1'b0;
      else if (rise_evt && bit_cnt == 4'd15)  reload_pend <= 1'b1;
      else if (fall_evt)                      reload_pend <= 1'b0;

      if (enter || ferr_evt) rx_sh <= '0;
      else if (rise_evt)     rx_sh <= {rx_sh[14:0], mosi_s};

      done_q     <= rise_evt & (bit_cnt == 4'd15);
      RX_OVERRUN <= 1'b0;
      FRAME_ERR  <= ferr_evt;
      if (done_q) begin
        if (RX_VALID && !RX_ACK) RX_OVERRUN <= 1'b1;
        else begin
          RX_DATA  <= rx_sh;
          RX_VALID <= 1'b1;
        end
      end else if (RX_ACK) begin
        RX_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_port.sv
// Directed + randomized bench for spi_slave_port acting as an SPI mode-0 master,
// checked against a word-level model of the TX holding and RX output registers.
`timescale 1ns/1ps
module tb_spi_slave_port;
  localparam int S    = 2;
  localparam int HALF = 6;

  logic        MCLK = 1'b0, RESET_N = 1'b0, SCLK = 1'b0, CSS = 1'b1, MOSI = 1'b0;
  logic        TX_LOAD = 1'b0, RX_ACK = 1'b0;
  logic [15:0] TX_DATA = '0;
  logic        MISO, TX_FULL, RX_VALID, RX_OVERRUN, FRAME_ERR, BUSY;
  logic [15:0] RX_DATA;

  spi_slave_port #(.SYNC_STAGES(S)) dut (
    .MCLK(MCLK), .RESET_N(RESET_N), .SCLK(SCLK), .CSS(CSS), .MOSI(MOSI), .MISO(MISO),
    .TX_DATA(TX_DATA), .TX_LOAD(TX_LOAD), .TX_FULL(TX_FULL), .RX_DATA(RX_DATA),
    .RX_VALID(RX_VALID), .RX_ACK(RX_ACK), .RX_OVERRUN(RX_OVERRUN),
    .FRAME_ERR(FRAME_ERR), .BUSY(BUSY));

  always #5 MCLK = ~MCLK;

  int   vectors = 0, miscompares = 0;
  int   ovr_cnt = 0, ferr_cnt = 0, rxv_cnt = 0;
  logic rxv_prev = 1'b0;

  always @(negedge MCLK) begin
    if (RX_OVERRUN === 1'b1) ovr_cnt++;
    if (FRAME_ERR === 1'b1)  ferr_cnt++;
    if (RX_VALID === 1'b1 && rxv_prev !== 1'b1) rxv_cnt++;
    rxv_prev = RX_VALID;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // word-level reference state
  logic [15:0] m_hold = '0, m_data = '0;
  logic        m_full = 1'b0, m_valid = 1'b0;
  int          m_ovr = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_start(output logic [15:0] w);
    w = m_full ? m_hold : 16'h0000;
    m_full = 1'b0;
  endtask

  task automatic m_done(input logic [15:0] w, input bit ack_co);
    if (m_valid && !ack_co) m_ovr++;
    else begin m_data = w; m_valid = 1'b1; end
  endtask

  task automatic do_load(input logic [15:0] d);
    TX_LOAD = 1'b1; TX_DATA = d;
    @(negedge MCLK);
    TX_LOAD = 1'b0;
    @(negedge MCLK);
    m_hold = d; m_full = 1'b1;
  endtask

  task automatic do_ack();
    RX_ACK = 1'b1;
    @(negedge MCLK);
    RX_ACK = 1'b0;
    @(negedge MCLK);
    m_valid = 1'b0;
  endtask

  // One SCLK period; MISO is sampled just before the rising edge, as a master would.
  task automatic spi_bit(input logic b, input bit ack_co, output logic mi);
    MOSI = b;
    repeat (HALF) @(negedge MCLK);
    mi = MISO;
    SCLK = 1'b1;
    if (ack_co) begin
      repeat (S + 1) @(negedge MCLK);
      RX_ACK = 1'b1;
      @(negedge MCLK);
      RX_ACK = 1'b0;
      repeat (HALF - S - 2) @(negedge MCLK);
    end else repeat (HALF) @(negedge MCLK);
    SCLK = 1'b0;
  endtask

  task automatic spi_word(input logic [15:0] w, input bit ack_co, output logic [15:0] mi);
    logic b;
    mi = '0;
    for (int i = 15; i >= 0; i--) begin
      spi_bit(w[i], ack_co && (i == 0), b);
      mi[i] = b;
    end
  endtask

  task automatic cs_low(input bit bypass, input logic [15:0] d);
    CSS = 1'b0;
    if (bypass) begin
      repeat (S) @(negedge MCLK);
      TX_LOAD = 1'b1; TX_DATA = d;
      @(negedge MCLK);
      TX_LOAD = 1'b0;
      repeat (HALF - S - 1) @(negedge MCLK);
    end else repeat (HALF) @(negedge MCLK);
  endtask

  task automatic cs_high();
    repeat (HALF) @(negedge MCLK);
    CSS = 1'b1;
    repeat (2 * HALF) @(negedge MCLK);
  endtask

  task automatic frame(input string tag, input logic [15:0] w, input bit ack_co);
    logic [15:0] exp_tx, mi;
    m_start(exp_tx);
    cs_low(1'b0, 16'h0);
    spi_word(w, ack_co, mi);
    cs_high();
    m_done(w, ack_co);
    check({tag, ".miso"},  mi, exp_tx);
    check({tag, ".rxd"},   RX_DATA, m_data);
    check({tag, ".rxv"},   RX_VALID, m_valid);
    check({tag, ".txf"},   TX_FULL, m_full);
    check({tag, ".ovr"},   ovr_cnt, m_ovr);
  endtask

  initial begin
    logic [15:0] w1, w2, mi1, mi2, rnd;
    logic        b;
    int          snap_ovr, snap_ferr, snap_rxv;

    repeat (4) @(negedge MCLK);
    check("rst.miso", MISO, 1'b0);
    check("rst.txf",  TX_FULL, 1'b0);
    check("rst.rxv",  RX_VALID, 1'b0);
    check("rst.rxd",  RX_DATA, 16'h0);
    check("rst.ovr",  RX_OVERRUN, 1'b0);
    check("rst.ferr", FRAME_ERR, 1'b0);
    check("rst.busy", BUSY, 1'b0);
    RESET_N = 1'b1;
    repeat (6) @(negedge MCLK);

    do_load(16'hA5C3);
    check("load.txf", TX_FULL, 1'b1);
    frame("basic", 16'h1234, 1'b0);
    do_ack();
    check("ack.rxv", RX_VALID, 1'b0);

    frame("notx", 16'h5A96, 1'b0);
    do_ack();

    snap_ovr = ovr_cnt;
    frame("ovr1", 16'h0001, 1'b0);
    frame("ovr2", 16'h0002, 1'b0);
    check("ovr.once", ovr_cnt - snap_ovr, 1);
    check("ovr.keep", RX_DATA, 16'h0001);
    frame("ackco", 16'h0002, 1'b1);
    check("ackco.novr", ovr_cnt - snap_ovr, 1);
    check("ackco.rxd", RX_DATA, 16'h0002);
    do_ack();

    frame("pre_ferr", 16'hC3C3, 1'b0);
    snap_ferr = ferr_cnt;
    m_start(w1);
    cs_low(1'b0, 16'h0);
    for (int i = 0; i < 7; i++) spi_bit(1'b1, 1'b0, b);
    cs_high();
    check("ferr.pulse", ferr_cnt - snap_ferr, 1);
    check("ferr.rxv",   RX_VALID, 1'b1);
    check("ferr.rxd",   RX_DATA, 16'hC3C3);
    check("ferr.busy",  BUSY, 1'b0);
    do_ack();
    frame("post_ferr", 16'h7E81, 1'b0);
    check("post_ferr.noerr", ferr_cnt - snap_ferr, 1);
    do_ack();

    snap_rxv = rxv_cnt;
    m_start(w1);
    cs_low(1'b0, 16'h0);
    mi1 = '0;
    for (int i = 15; i >= 0; i--) begin
      spi_bit(1'b1, 1'b0, b);
      mi1[i] = b;
      if (i == 8) do_load(16'h0F0F);
    end
    m_done(16'hFFFF, 1'b0);
    check("b2b.rxd1", RX_DATA, 16'hFFFF);
    do_ack();
    m_start(w2);
    spi_word(16'h8001, 1'b0, mi2);
    cs_high();
    m_done(16'h8001, 1'b0);
    check("b2b.miso1", mi1, w1);
    check("b2b.miso2", mi2, 16'h0F0F);
    check("b2b.model2", w2, 16'h0F0F);
    check("b2b.rxd2", RX_DATA, 16'h8001);
    check("b2b.events", rxv_cnt - snap_rxv, 2);
    do_ack();

    cs_low(1'b1, 16'h3C5A);
    m_hold = 16'h3C5A;
    spi_word(16'h9669, 1'b0, mi1);
    cs_high();
    m_done(16'h9669, 1'b0);
    check("byp.miso", mi1, 16'h3C5A);
    check("byp.txf",  TX_FULL, 1'b0);
    check("byp.rxd",  RX_DATA, 16'h9669);

    snap_ferr = ferr_cnt;
    cs_low(1'b0, 16'h0);
    for (int i = 0; i < 4; i++) spi_bit(1'b0, 1'b0, b);
    do_load(16'h1111);
    for (int i = 0; i < 5; i++) spi_bit(1'b1, 1'b0, b);
    check("mid.txf", TX_FULL, 1'b1);
    RESET_N = 1'b0;
    CSS = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    repeat (2) @(negedge MCLK);
    check("mrst.miso", MISO, 1'b0);
    check("mrst.txf",  TX_FULL, 1'b0);
    check("mrst.rxv",  RX_VALID, 1'b0);
    check("mrst.rxd",  RX_DATA, 16'h0);
    check("mrst.busy", BUSY, 1'b0);
    m_valid = 1'b0; m_full = 1'b0; m_data = '0;
    RESET_N = 1'b1;
    repeat (8) @(negedge MCLK);
    check("mrst.noerr", ferr_cnt - snap_ferr, 0);
    check("mrst.rxv2",  RX_VALID, 1'b0);
    frame("beef", 16'hBEEF, 1'b0);
    do_ack();

    for (int n = 0; n < 12; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        rnd = 16'($urandom);
        do_load(rnd);
      end
      if (m_valid && $urandom_range(0, 1) == 1) do_ack();
      rnd = 16'($urandom);
      frame("rand", rnd, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
